// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package prio_enc_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Width of an index into an n-entry vector, never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set bit of vec at or above start, wrapping N-1 -> 0.
module prio_pick
   import prio_enc_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = idx_width(N)
) (
   input  logic [N-1:0] i_vec,
   input  logic [W-1:0] i_start,
   output logic [W-1:0] o_idx,
   output logic         o_found
);

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         int p;
         p = int'(i_start) + k;
         // Wrap at N rather than 2^W so non-power-of-two sizes stay in range.
         if (p >= int'(N)) p = p - int'(N);
         if (!o_found && i_vec[p]) begin
            o_idx   = W'(p);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered priority encoder with fixed or round-robin search and a saturating error count.
module prio_enc_rr
   import prio_enc_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = 8,
   parameter int unsigned W  = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  din,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic          mode,
   output logic [W-1:0]  dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          multi,
   output logic          none,
   output logic [CW-1:0] err_cnt
);

   logic [W-1:0]  r_dout;
   logic          r_dout_valid;
   logic          r_multi;
   logic          r_none;
   logic [CW-1:0] r_err_cnt;
   logic [W-1:0]  r_ptr;

   logic          w_accept;
   logic [W-1:0]  w_start;
   logic [W-1:0]  w_idx;
   logic          w_found;
   logic          w_multi;
   logic [W-1:0]  w_ptr_next;

   assign din_ready = !r_dout_valid || dout_ready;
   assign w_accept  = din_valid && din_ready;
   assign w_start   = (mode == MODE_RR) ? r_ptr : '0;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign w_multi   = |(din & (din - N'(1)));
   assign w_ptr_next = (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);

   prio_pick #(
      .N(N),
      .W(W)
   ) u_pick (
      .i_vec  (din),
      .i_start(w_start),
      .o_idx  (w_idx),
      .o_found(w_found)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_multi      <= 1'b0;
         r_none       <= 1'b0;
         r_err_cnt    <= '0;
         r_ptr        <= '0;
      end else begin
         if (w_accept) begin
            r_dout       <= w_found ? w_idx : '0;
            r_dout_valid <= 1'b1;
            r_multi      <= w_multi;
            r_none       <= !w_found;
            if ((w_multi || !w_found) && (r_err_cnt != '1)) begin
               r_err_cnt <= r_err_cnt + CW'(1);
            end
            if ((mode != MODE_FIXED) && w_found) begin
               r_ptr <= w_ptr_next;
            end
         end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign multi      = r_multi;
   assign none       = r_none;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Randomized and directed checks of prio_enc_rr (N=8) against a behavioural model.
module tb_prio_enc_rr;

   localparam int N  = 8;
   localparam int CW = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   din;
   logic         din_valid;
   logic         din_ready;
   logic         mode;
   logic [2:0]   dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         multi;
   logic         none;
   logic [7:0]   err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   int   m_ptr;
   int   m_err;
   int   m_dout;
   logic m_valid;
   logic m_multi;
   logic m_none;

   always #5 clk = ~clk;

   prio_enc_rr #(
      .N (N),
      .CW(CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .mode      (mode),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .multi     (multi),
      .none      (none),
      .err_cnt   (err_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner: lowest set index (fixed), or smallest set index >= start, else lowest (rr).
   function automatic int ref_pick(input logic [7:0] v, input int start, input logic rr);
      int lo = -1;
      int hi = -1;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            if (lo < 0) lo = i;
            if (rr && i >= start && hi < 0) hi = i;
         end
      end
      if (lo < 0) return 0;
      if (!rr) return lo;
      return (hi >= 0) ? hi : lo;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_err = 0; m_dout = 0;
      m_valid = 1'b0; m_multi = 1'b0; m_none = 1'b0;
   endtask

   // One clock: drive after negedge, check ready, model the edge, check outputs at next negedge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic m, input logic rdy);
      logic acc;
      int   ones;
      din_valid = v; din = d; mode = m; dout_ready = rdy;
      #1;
      check_eq("din_ready", din_ready, !m_valid || rdy);
      acc = v && (!m_valid || rdy);
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (acc) begin
         ones    = $countones(d);
         m_dout  = ref_pick(d, m_ptr, m);
         m_valid = 1'b1;
         m_multi = (ones >= 2);
         m_none  = (ones == 0);
         if ((m_multi || m_none) && m_err < 255) m_err++;
         if (m && ones != 0) m_ptr = (m_dout + 1) % N;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      check_eq("dout_valid", dout_valid, m_valid);
      check_eq("err_cnt", err_cnt, m_err);
      if (m_valid) begin
         check_eq("dout", dout, m_dout);
         check_eq("multi", multi, m_multi);
         check_eq("none", none, m_none);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; din = '0; din_valid = 1'b0; mode = 1'b0; dout_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_dout", dout, 0);
      check_eq("rst_valid", dout_valid, 0);
      check_eq("rst_multi", multi, 0);
      check_eq("rst_none", none, 0);
      check_eq("rst_err", err_cnt, 0);
      check_eq("rst_ready", din_ready, 1);
      rst_n = 1'b1;

      // Fixed-mode one-hot walk
      for (int i = 0; i < N; i++) begin
         cycle(1'b1, 8'h01 << i, 1'b0, 1'b1);
         check_eq("walk_dout", dout, i);
         check_eq("walk_multi", multi, 0);
         check_eq("walk_none", none, 0);
      end

      // Round-robin over a full vector wraps the pointer
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'hFF, 1'b1, 1'b1);
         check_eq("rr_ff_dout", dout, i % N);
      end

      // Two-bit vector alternates between its ends
      do_reset();
      cycle(1'b1, 8'h81, 1'b1, 1'b1);
      check_eq("rr81_a", dout, 0);
      cycle(1'b1, 8'h81, 1'b1, 1'b1);
      check_eq("rr81_b", dout, 7);
      cycle(1'b1, 8'h81, 1'b1, 1'b1);
      check_eq("rr81_c", dout, 0);
      check_eq("rr81_multi", multi, 1);
      check_eq("rr81_err", err_cnt, 3);

      // Backpressure: result held, input ignored, then drain and accept together
      do_reset();
      cycle(1'b1, 8'h04, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
         check_eq("bp_hold", dout, 2);
         check_eq("bp_valid", dout_valid, 1);
      end
      cycle(1'b1, 8'h10, 1'b0, 1'b1);
      check_eq("bp_release", dout, 4);

      // All-zero accepts saturate the error counter
      do_reset();
      for (int i = 0; i < 300; i++) cycle(1'b1, 8'h00, 1'($urandom), 1'b1);
      check_eq("sat_err", err_cnt, 255);
      check_eq("sat_none", none, 1);
      check_eq("sat_dout", dout, 0);

      // Reset under stall discards the held result and the pointer
      do_reset();
      cycle(1'b1, 8'h30, 1'b1, 1'b1);
      cycle(1'b1, 8'h30, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check_eq("srst_valid", dout_valid, 0);
      check_eq("srst_err", err_cnt, 0);
      rst_n = 1'b1;
      cycle(1'b1, 8'hFF, 1'b1, 1'b1);
      check_eq("srst_ptr", dout, 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
         rst_n = ($urandom_range(0, 60) != 0);
         cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 Parameter N, default 8: number of request inputs; legal range 2..64.
REQ-002 Parameter W, default $clog2(N): output index width; derived, never overridden.
REQ-003 Parameter CW, default 8: width of the error counter.
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port din  in  N  request vector; bit i is input i.
REQ-007 Port din_valid  in  1  din is presented.
REQ-008 Port din_ready  out  1  block accepts din this cycle.
REQ-009 Port mode  in  1  0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-010 Port dout  out  W  encoded index of the winning request.
REQ-011 Port dout_valid  out  1  dout and flags are valid.
REQ-012 Port dout_ready  in  1  downstream accepts the result.
REQ-013 Port multi  out  1  accepted din had more than one bit set.
REQ-014 Port none  out  1  accepted din was all-zero.
REQ-015 Port err_cnt  out  CW  saturating count of accepted vectors with multi or none set.

Function
REQ-016 Accept occurs when din_valid && din_ready; din_ready = !dout_valid || dout_ready, combinational.
REQ-017 Latency is one cycle: on accept, dout/multi/none register on the same edge and dout_valid=1 from the next cycle.
REQ-018 Output hold: while dout_valid && !dout_ready, dout, multi, none and dout_valid stay constant.
REQ-019 dout_valid clears on dout_ready && !(accept); on simultaneous drain and accept it stays 1 with the new result (full throughput, one result per cycle).
REQ-020 Fixed mode: the winner is the lowest set index; a one-hot din at bit i gives dout=i.
REQ-021 Round-robin mode: search starts at pointer ptr (W bits) and proceeds upward with wrap N-1 -> 0; the first set bit wins.
REQ-022 ptr updates only on accept in mode 1 with a non-zero din: ptr <= (winner+1) mod N; non-power-of-2 N wraps at N, not 2^W.
REQ-023 ptr holds in mode 0 and on an all-zero accept; mode is sampled only at accept.
REQ-024 All-zero din accepted -> dout=0, none=1, multi=0, dout_valid=1; ptr unchanged.
REQ-025 multi=1 iff popcount(din)>=2; the winner is still encoded per mode.
REQ-026 err_cnt increments by 1 on each accept with multi||none; it saturates at 2^CW-1 and never wraps.
REQ-027 A din_valid without ready is not accepted; din may change freely with no effect on state.

Reset
REQ-028 While rst_n=0 at a clock edge: dout=0, dout_valid=0, multi=0, none=0, err_cnt=0, ptr=0.
REQ-029 Reset mid-operation discards any held result with no downstream handshake; din_ready=1 in the first cycle after reset release.
REQ-030 No output is X after the first clock edge with rst_n=0.

Structure
REQ-031 A shared package prio_enc_pkg holds the mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1, plus the index-width function.
REQ-032 One sub-module, prio_pick (combinational), maps (vector, start index) to (index, found).
  - Fixed mode uses start 0.
  - The top holds the registers, handshake, ptr and counter.
  - Target size: 150-300 lines total.

Verification (N=8)
REQ-033 Fixed mode, one-hot walk din=8'h01..8'h80, dout_ready=1.
  - Required response: dout=0..7, one cycle later each, multi=0, none=0.
REQ-034 Round-robin mode, din=8'hFF held for 10 accepts after reset.
  - Required response: dout=0,1,...,7,0,1; ptr wraps.
REQ-035 Round-robin mode, din=8'h81, ptr=0.
  - Required response: dout=0, then 7, then 0.
  - multi=1 each time; err_cnt reaches 3.
REQ-036 Backpressure: accept 8'h04, hold dout_ready=0 for 5 cycles while din changes.
  - Required response: dout=2 held, din_ready=0; on release, the next din is accepted in the same cycle as the drain.
REQ-037 din=8'h00 accepted 300 times with CW=8.
  - Required response: none=1, dout=0, err_cnt saturates at 255.
REQ-038 Assert rst_n=0 while dout_valid=1 under stall.
  - Required response: next cycle dout_valid=0, err_cnt=0, ptr=0.
